// File: rtl/lsu_port_arbiter_if.sv
// Requester/LSU bundle for the two-port LSU arbiter.
// The arbiter connects through "slave"; the environment driving requests and modelling the LSU uses "master".
interface lsu_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [DATA_W-1:0] m1_rdata_o;

  logic              lsu_st_en_o;
  logic [ADDR_W-1:0] lsu_addr_o;
  logic [DATA_W-1:0] lsu_st_data_o;
  logic [DATA_W-1:0] lsu_ld_data_i;
  logic              busy_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  lsu_ld_data_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output lsu_st_en_o, lsu_addr_o, lsu_st_data_o, busy_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output lsu_ld_data_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  lsu_st_en_o, lsu_addr_o, lsu_st_data_o, busy_o
  );
endinterface

// File: rtl/lsu_port_arbiter.sv
// Two-port sticky-priority arbiter in front of the shared LSU (CPU on port 0, debug/loader on port 1).
// Grants are combinational; load data is registered and returned one cycle after the grant.
module lsu_port_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  lsu_port_arbiter_if.slave bus
);
  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  port_e             owner_q, owner_d;
  logic [3:0]        hold_q, hold_d;
  port_e             rsp_port_q, rsp_port_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  port_e             winner;
  logic              any_req, both_req, grant;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    any_req  = bus.m0_req_i | bus.m1_req_i;
    both_req = bus.m0_req_i & bus.m1_req_i;
    if (both_req) begin
      winner = (hold_q < HOLD_MAX) ? owner_q : port_e'(~owner_q);
    end else begin
      winner = bus.m1_req_i ? PORT1 : PORT0;
    end
    // Reset masks the grant so an in-flight store cannot reach the LSU.
    grant    = any_req & rst_ni;
    win_we   = (winner == PORT1) ? bus.m1_we_i    : bus.m0_we_i;
    win_addr = (winner == PORT1) ? bus.m1_addr_i  : bus.m0_addr_i;
    win_data = (winner == PORT1) ? bus.m1_wdata_i : bus.m0_wdata_i;
  end

  always_comb begin
    owner_d     = owner_q;
    hold_d      = '0;
    rsp_valid_d = 1'b0;
    rsp_port_d  = rsp_port_q;
    rsp_data_d  = rsp_data_q;
    if (grant) begin
      if (winner != owner_q) begin
        owner_d = winner;
        hold_d  = both_req ? 4'd1 : '0;
      end else if (both_req) begin
        hold_d = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 4'd1;
      end
      if (!win_we) begin
        rsp_valid_d = 1'b1;
        rsp_port_d  = winner;
        rsp_data_d  = bus.lsu_ld_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q     <= PORT0;
      hold_q      <= '0;
      rsp_port_q  <= PORT0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      rsp_port_q  <= rsp_port_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.m0_gnt_o      = grant & (winner == PORT0);
  assign bus.m1_gnt_o      = grant & (winner == PORT1);
  assign bus.lsu_st_en_o   = grant & win_we;
  assign bus.lsu_addr_o    = win_addr;
  assign bus.lsu_st_data_o = win_data;

  assign bus.m0_rvalid_o   = rsp_valid_q & (rsp_port_q == PORT0);
  assign bus.m1_rvalid_o   = rsp_valid_q & (rsp_port_q == PORT1);
  assign bus.m0_rdata_o    = (rsp_port_q == PORT0) ? rsp_data_q : '0;
  assign bus.m1_rdata_o    = (rsp_port_q == PORT1) ? rsp_data_q : '0;
  assign bus.busy_o        = grant | rsp_valid_q;
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Bench for lsu_port_arbiter: directed scenarios then randomized traffic, checked against a
// transaction-level model of the arbitration rules and a reference memory.
module tb_lsu_port_arbiter;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_port_arbiter #(.MAX_HOLD(MH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  function automatic logic [7:0] idx(input logic [31:0] a);
    return {a[14:12], a[6:2]};
  endfunction

  // Behavioural LSU: combinational read, write on the rising edge.
  logic [31:0] mem [256] = '{default: '0};
  assign bus.lsu_ld_data_i = mem[idx(bus.lsu_addr_o)];
  always @(posedge clk) if (bus.lsu_st_en_o) mem[idx(bus.lsu_addr_o)] <= bus.lsu_st_data_o;

  // Reference model state
  logic [31:0] ref_mem [256] = '{default: '0};
  bit          m_owner;
  int          m_streak;
  bit          exp_rv0, exp_rv1;
  bit          m_rsp_port;
  logic [31:0] m_rsp_data;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_owner    = 1'b0;
    m_streak   = 0;
    exp_rv0    = 1'b0;
    exp_rv1    = 1'b0;
    m_rsp_port = 1'b0;
    m_rsp_data = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(7) << 12) | ($urandom_range(31) << 2);
    return a;
  endfunction

  task automatic drive(input bit r0, w0, input logic [31:0] a0, d0,
                       input bit r1, w1, input logic [31:0] a1, d1);
    bus.m0_req_i = r0; bus.m0_we_i = w0; bus.m0_addr_i = a0; bus.m0_wdata_i = d0;
    bus.m1_req_i = r1; bus.m1_we_i = w1; bus.m1_addr_i = a1; bus.m1_wdata_i = d1;
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input bit r0, w0, input logic [31:0] a0, d0,
                      input bit r1, w1, input logic [31:0] a1, d1,
                      output bit win, output bit anyr, output logic obs_g1);
    bit both, ww;
    logic [31:0] wa, wd;
    chk("m0_rvalid", bus.m0_rvalid_o, exp_rv0);
    chk("m1_rvalid", bus.m1_rvalid_o, exp_rv1);
    chk("m0_rdata", bus.m0_rdata_o, (m_rsp_port == 1'b0) ? m_rsp_data : 32'h0);
    chk("m1_rdata", bus.m1_rdata_o, (m_rsp_port == 1'b1) ? m_rsp_data : 32'h0);
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    #2;
    anyr = r0 | r1;
    both = r0 & r1;
    if (both) win = (m_streak < MH) ? m_owner : !m_owner;
    else      win = r1;
    ww = win ? w1 : w0;
    wa = win ? a1 : a0;
    wd = win ? d1 : d0;
    chk("m0_gnt", bus.m0_gnt_o, anyr && !win);
    chk("m1_gnt", bus.m1_gnt_o, anyr && win);
    chk("st_en", bus.lsu_st_en_o, anyr && ww);
    chk("busy", bus.busy_o, anyr | exp_rv0 | exp_rv1);
    if (anyr) chk("lsu_addr", bus.lsu_addr_o, wa);
    if (anyr && ww) chk("lsu_st_data", bus.lsu_st_data_o, wd);
    obs_g1 = bus.m1_gnt_o;
    @(posedge clk);
    #1;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (anyr) begin
      if (win != m_owner) begin
        m_owner  = win;
        m_streak = both ? 1 : 0;
      end else begin
        m_streak = both ? ((m_streak < MH) ? m_streak + 1 : MH) : 0;
      end
      if (ww) begin
        ref_mem[idx(wa)] = wd;
      end else begin
        m_rsp_port = win;
        m_rsp_data = ref_mem[idx(wa)];
        if (win) exp_rv1 = 1'b1;
        else     exp_rv0 = 1'b1;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic idle();
    bit w, a;
    logic g;
    step(0, 0, 0, 0, 0, 0, 0, 0, w, a, g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit win, anyr;
    logic g1;
    bit p0_pend, p1_pend;
    bit p0_r, p0_w, p1_r, p1_w;
    logic [31:0] p0_a, p0_d, p1_a, p1_d;

    // Reset held for two edges with a port 0 request pending
    drive(1, 0, 32'h3000, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_m0_gnt", bus.m0_gnt_o, 0);
      chk("rst_m1_gnt", bus.m1_gnt_o, 0);
      chk("rst_m0_rvalid", bus.m0_rvalid_o, 0);
      chk("rst_m1_rvalid", bus.m1_rvalid_o, 0);
      chk("rst_m0_rdata", bus.m0_rdata_o, 0);
      chk("rst_m1_rdata", bus.m1_rdata_o, 0);
      chk("rst_st_en", bus.lsu_st_en_o, 0);
    end
    rst_n = 1'b1;
    model_reset();

    // Fairness from reset: both ports loading continuously -> m0 x4, m1 x4, ...
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 32'h1004, 0, 1, 0, 32'h2008, 0, win, anyr, g1);
      chk("fair_seq", g1, (i / 4) % 2);
    end
    idle();

    // Single-port store then load of the same address
    step(1, 1, 32'h3000, 32'h8, 0, 0, 0, 0, win, anyr, g1);
    step(1, 0, 32'h3000, 0, 0, 0, 0, 0, win, anyr, g1);
    chk("sp_rvalid0", bus.m0_rvalid_o, 1);
    chk("sp_rvalid1", bus.m1_rvalid_o, 0);
    chk("sp_rdata0", bus.m0_rdata_o, 32'h8);
    idle();

    // Cross-port coherence through the LEDR region
    step(0, 0, 0, 0, 1, 1, 32'h7000, 32'h1234, win, anyr, g1);
    step(1, 0, 32'h7000, 0, 0, 0, 0, 0, win, anyr, g1);
    chk("xp_rdata0", bus.m0_rdata_o, 32'h1234);
    chk("xp_rdata1", bus.m1_rdata_o, 0);
    idle();

    // Owner idle: m1 alone takes ownership without building up hold count
    step(1, 0, 32'h1004, 0, 0, 0, 0, 0, win, anyr, g1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0, 32'h2008 + 32'(i * 4), 0, win, anyr, g1);
      chk("oi_m1_gnt", g1, 1);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 32'h1004, 0, 1, 0, 32'h2008, 0, win, anyr, g1);
      chk("oi_contest", g1, (i < 4) ? 1 : 0);
    end
    idle();

    // Reset during a granted store: write must not commit
    step(0, 0, 0, 0, 1, 0, 32'h2008, 0, win, anyr, g1);
    idle();
    drive(1, 1, 32'h3000, 32'hDEADBEEF, 0, 0, 0, 0);
    #2;
    chk("rs_gnt0", bus.m0_gnt_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_st_en", bus.lsu_st_en_o, 0);
    chk("rs_gnt0_low", bus.m0_gnt_o, 0);
    @(posedge clk);
    #1;
    chk("rs_rvalid0", bus.m0_rvalid_o, 0);
    chk("rs_rvalid1", bus.m1_rvalid_o, 0);
    rst_n = 1'b1;
    model_reset();

    // Reset during a granted load with m1 as owner: no rvalid, owner back to 0
    step(0, 0, 0, 0, 1, 0, 32'h2008, 0, win, anyr, g1);
    idle();
    drive(1, 0, 32'h3000, 0, 0, 0, 0, 0);
    #2;
    chk("rl_gnt0", bus.m0_gnt_o, 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rl_rvalid0", bus.m0_rvalid_o, 0);
    chk("rl_rdata0", bus.m0_rdata_o, 0);
    rst_n = 1'b1;
    model_reset();
    step(1, 0, 32'h1004, 0, 1, 0, 32'h2008, 0, win, anyr, g1);
    chk("rl_owner0", g1, 0);
    step(0, 0, 0, 0, 1, 0, 32'h2008, 0, win, anyr, g1);
    step(1, 0, 32'h3000, 0, 0, 0, 0, 0, win, anyr, g1);
    idle();
    chk("rl_mem_kept", bus.m0_rdata_o, 32'h8);

    // Randomized traffic; ungranted requests are held stable
    p0_pend = 1'b0;
    p1_pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!p0_pend) begin
        p0_r = ($urandom_range(3) != 0);
        p0_w = $urandom_range(1) == 1;
        p0_a = rand_addr();
        p0_d = $urandom();
      end
      if (!p1_pend) begin
        p1_r = ($urandom_range(3) != 0);
        p1_w = $urandom_range(1) == 1;
        p1_a = rand_addr();
        p1_d = $urandom();
      end
      step(p0_r, p0_w, p0_a, p0_d, p1_r, p1_w, p1_a, p1_d, win, anyr, g1);
      p0_pend = p0_r && !(anyr && !win);
      p1_pend = p1_r && !(anyr && win);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
